// File: rtl/data_mem_seq_if.sv
// Request/response bus between the load/store unit and data_mem_seq.
// Latency: n/a (wires only).
// Backpressure: Ready from the slave qualifies Valid from the master.
// Optional: DATA_MEM_PARITY_EN adds the ParityErr response signal.
interface data_mem_seq_if #(
  parameter int W = 8,
  parameter int A = 8
);
  logic         Valid;
  logic [1:0]   Op;
  logic [A-1:0] Addr;
  logic [W-1:0] DataIn;
  logic         Ready;
  logic [W-1:0] DataOut;
  logic         RdValid;
  logic         Carry;
`ifdef DATA_MEM_PARITY_EN
  logic         ParityErr;

  modport master (output Valid, Op, Addr, DataIn,
                  input  Ready, DataOut, RdValid, Carry, ParityErr);
  modport slave  (input  Valid, Op, Addr, DataIn,
                  output Ready, DataOut, RdValid, Carry, ParityErr);
`else
  modport master (output Valid, Op, Addr, DataIn,
                  input  Ready, DataOut, RdValid, Carry);
  modport slave  (input  Valid, Op, Addr, DataIn,
                  output Ready, DataOut, RdValid, Carry);
`endif
endinterface

// File: rtl/data_mem_seq.sv
// Single-port W x 2**A data memory with registered reads, atomic INC and reset-time table preload.
// Latency: READ 1 cycle, INC 2 cycles (old value returned, old+1 written); WRITE lands at the accept edge.
// Backpressure: Ready=0 during the 12-cycle init and the INC2 cycle; requests then are dropped, not queued.
// Optional: DATA_MEM_PARITY_EN stores an even-parity bit per entry and reports ParityErr with RdValid.
module data_mem_seq #(
  parameter int W         = 8,
  parameter int A         = 8,
  parameter int MASK_BASE = 180,
  parameter int CNT_BASE  = 200
) (
  input  logic          Clk,
  input  logic          Reset,
  data_mem_seq_if.slave bus
);

  localparam int DEPTH = 1 << A;
`ifdef DATA_MEM_PARITY_EN
  localparam int MW = W + 1;
`else
  localparam int MW = W;
`endif

  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_INC   = 2'b11;
  localparam logic [3:0] TBL_LAST = 4'd11;

  typedef enum logic [1:0] {INIT, IDLE, INC2} state_t;

  logic [MW-1:0] mem [DEPTH];

  state_t       state;
  logic [3:0]   idx;
  logic [A-1:0] lat;
  logic [W-1:0] old;
  logic         ready_q;
  logic [W-1:0] dout_q;
  logic         rdv_q;
  logic         carry_q;

  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [W-1:0] wr_dat;
  logic [MW-1:0] rd_word;

  // Constant table: ten mask constants followed by the counter start/end pair.
  function automatic logic [W-1:0] tbl_dat(input logic [3:0] i);
    logic [7:0] v;
    case (i)
      4'd0:  v = 8'hF0;
      4'd1:  v = 8'h01;
      4'd2:  v = 8'hF0;
      4'd3:  v = 8'hE0;
      4'd4:  v = 8'hCC;
      4'd5:  v = 8'hC8;
      4'd6:  v = 8'hAA;
      4'd7:  v = 8'hA8;
      4'd8:  v = 8'hFF;
      4'd9:  v = 8'hFE;
      4'd10: v = 8'h00;
      4'd11: v = 8'h20;
      default: v = 8'h00;
    endcase
    return W'(v);
  endfunction

  function automatic logic [A-1:0] tbl_addr(input logic [3:0] i);
    if (i < 4'd10) return A'(MASK_BASE) + A'(i);
    else           return A'(CNT_BASE) + A'(i - 4'd10);
  endfunction

  assign rd_word = mem[bus.Addr];

  // Single write port arbitration: init preload, IDLE WRITE, or INC2 write-back; reset blocks all writes.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.Addr;
    wr_dat  = bus.DataIn;
    if (Reset) begin
      case (state)
        INIT: begin
          wr_en   = 1'b1;
          wr_addr = tbl_addr(idx);
          wr_dat  = tbl_dat(idx);
        end
        IDLE: wr_en = bus.Valid && (bus.Op == OP_WRITE);
        INC2: begin
          wr_en   = 1'b1;
          wr_addr = lat;
          wr_dat  = old + W'(1);
        end
        default: wr_en = 1'b0;
      endcase
    end
  end

  // Storage array; contents are never cleared by reset.
  always_ff @(posedge Clk) begin
`ifdef DATA_MEM_PARITY_EN
    if (wr_en) mem[wr_addr] <= {^wr_dat, wr_dat};
`else
    if (wr_en) mem[wr_addr] <= wr_dat;
`endif
  end

`ifdef DATA_MEM_PARITY_EN
  logic perr_q;
  logic old_perr;
  assign bus.ParityErr = perr_q;
`endif

  // Control FSM with registered handshake and read-response outputs.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= INIT;
      idx     <= '0;
      lat     <= '0;
      old     <= '0;
      ready_q <= 1'b0;
      dout_q  <= '0;
      rdv_q   <= 1'b0;
      carry_q <= 1'b0;
`ifdef DATA_MEM_PARITY_EN
      perr_q   <= 1'b0;
      old_perr <= 1'b0;
`endif
    end else begin
      rdv_q <= 1'b0;
      case (state)
        INIT: begin
          if (idx == TBL_LAST) begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        IDLE: begin
          if (bus.Valid) begin
            if (bus.Op == OP_READ) begin
              dout_q  <= rd_word[W-1:0];
              rdv_q   <= 1'b1;
              carry_q <= 1'b0;
`ifdef DATA_MEM_PARITY_EN
              perr_q  <= ^rd_word;
`endif
            end else if (bus.Op == OP_INC) begin
              lat     <= bus.Addr;
              old     <= rd_word[W-1:0];
              state   <= INC2;
              ready_q <= 1'b0;
`ifdef DATA_MEM_PARITY_EN
              old_perr <= ^rd_word;
`endif
            end
          end
        end
        INC2: begin
          dout_q  <= old;
          rdv_q   <= 1'b1;
          carry_q <= &old;
          state   <= IDLE;
          ready_q <= 1'b1;
`ifdef DATA_MEM_PARITY_EN
          perr_q  <= old_perr;
`endif
        end
        default: begin
          state   <= INIT;
          idx     <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Ready   = ready_q;
  assign bus.DataOut = dout_q;
  assign bus.RdValid = rdv_q;
  assign bus.Carry   = carry_q;

endmodule

// File: tb/tb_data_mem_seq.sv
// Scoreboard bench for data_mem_seq: directed requests push expected responses, a monitor checks them.
module tb_data_mem_seq;

  localparam logic [1:0] NOP = 2'b00, RD = 2'b01, WR = 2'b10, INC = 2'b11;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [7:0] d;
    logic       c;
    logic       pe;
    int         at;
  } exp_t;
  exp_t sb[$];

  data_mem_seq_if #(.W(8), .A(8)) bus ();

  data_mem_seq #(.W(8), .A(8), .MASK_BASE(180), .CNT_BASE(200)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every RdValid pulse must match the oldest expected response, including its cycle.
  always @(negedge Clk) begin
    if (bus.RdValid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdvalid: got RdValid=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rd_data", bus.DataOut, e.d);
        chk("rd_carry", bus.Carry, e.c);
        chk("rd_cycle", cyc, e.at);
`ifdef DATA_MEM_PARITY_EN
        chk("rd_parity", bus.ParityErr, e.pe);
`endif
      end
    end
  end

  task automatic expect_rd(input logic [7:0] d, input logic c, input logic pe, input int lat);
    exp_t e;
    e.d = d; e.c = c; e.pe = pe; e.at = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int g = 0;
    while (bus.Ready !== 1'b1 && g < 100) begin
      @(negedge Clk);
      g++;
    end
    if (g >= 100) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got Ready=0 for %0d cycles expected 1", g);
    end
  endtask

  // Issue one request at a negedge once Ready is seen; response expectations are queued first.
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] ed, input logic ec);
    @(negedge Clk);
    wait_ready();
    bus.Valid = 1'b1; bus.Op = op; bus.Addr = a; bus.DataIn = d;
    if (op == RD)  expect_rd(ed, 1'b0, 1'b0, 1);
    if (op == INC) expect_rd(ed, ec, 1'b0, 2);
    @(posedge Clk);
    #1 bus.Valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 20) begin
      @(negedge Clk);
      g++;
    end
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    int n;
    bus.Valid = 1'b0; bus.Op = NOP; bus.Addr = '0; bus.DataIn = '0;

    // Reset state.
    repeat (3) @(negedge Clk);
    chk("rst_ready", bus.Ready, 1'b0);
    chk("rst_rdvalid", bus.RdValid, 1'b0);
    chk("rst_carry", bus.Carry, 1'b0);
    chk("rst_dataout", bus.DataOut, 8'h00);

    // Hold a READ through init; it must be accepted only once Ready rises 12 cycles after release.
    bus.Valid = 1'b1; bus.Op = RD; bus.Addr = 8'd180;
    Reset = 1'b1;
    n = 0;
    while (bus.Ready !== 1'b1 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    chk("init_cycles", n, 12);
    expect_rd(8'hF0, 1'b0, 1'b0, 1);
    @(posedge Clk);
    #1 bus.Valid = 1'b0;

    issue(RD, 8'd201, 8'h00, 8'h20, 1'b0);
    issue(RD, 8'd187, 8'h00, 8'hA8, 1'b0);
    issue(RD, 8'd189, 8'h00, 8'hFE, 1'b0);

    // Write then immediate read-back; also top-of-range address.
    issue(WR, 8'h10, 8'h5A, 8'h00, 1'b0);
    issue(RD, 8'h10, 8'h00, 8'h5A, 1'b0);
    issue(WR, 8'hFF, 8'h3C, 8'h00, 1'b0);
    issue(NOP, 8'hFF, 8'h99, 8'h00, 1'b0);
    issue(RD, 8'hFF, 8'h00, 8'h3C, 1'b0);

    // Counter increments, honouring Ready between them.
    issue(INC, 8'd200, 8'h00, 8'h00, 1'b0);
    issue(INC, 8'd200, 8'h00, 8'h01, 1'b0);
    issue(INC, 8'd200, 8'h00, 8'h02, 1'b0);
    issue(RD,  8'd200, 8'h00, 8'h03, 1'b0);

    // Wrap: FF increments to 00 with Carry, and a later READ clears Carry.
    issue(WR,  8'h20, 8'hFF, 8'h00, 1'b0);
    issue(INC, 8'h20, 8'h00, 8'hFF, 1'b1);
    issue(RD,  8'h20, 8'h00, 8'h00, 1'b0);
    drain();

    // Reset during INC2 aborts the write-back and reloads the table.
    issue(WR, 8'h30, 8'h77, 8'h00, 1'b0);
    issue(WR, 8'd181, 8'h55, 8'h00, 1'b0);
    @(negedge Clk);
    wait_ready();
    bus.Valid = 1'b1; bus.Op = INC; bus.Addr = 8'h30;
    @(posedge Clk);
    #1 bus.Valid = 1'b0;
    @(negedge Clk);
    chk("inc2_ready_low", bus.Ready, 1'b0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("abort_rdvalid", bus.RdValid, 1'b0);
    chk("abort_ready", bus.Ready, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    issue(RD, 8'h30,  8'h00, 8'h77, 1'b0);
    issue(RD, 8'd181, 8'h00, 8'h01, 1'b0);
    issue(RD, 8'd200, 8'h00, 8'h00, 1'b0);
    issue(RD, 8'h10,  8'h00, 8'h5A, 1'b0);
    drain();

`ifdef DATA_MEM_PARITY_EN
    // Corrupt one data bit of 0x10 behind the parity bit.
    @(negedge Clk);
    dut.mem[16] = dut.mem[16] ^ 9'h001;
    @(negedge Clk);
    bus.Valid = 1'b1; bus.Op = RD; bus.Addr = 8'h10;
    expect_rd(8'h5B, 1'b0, 1'b1, 1);
    @(posedge Clk);
    #1 bus.Valid = 1'b0;
    drain();
`endif

    repeat (3) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends with a summary.
  initial begin
    #20000;
    errors++;
    $display("FAIL global_timeout: got no completion expected finish before 20000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
